// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with a first-word-fall-through receive FIFO and RTS flow control.
// Optional feature macro: UART_RX_MAJORITY_EN (2-of-3 majority vote around each bit centre).
module uart_rx_os #(
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int OVERSAMPLE   = 16,
    parameter int SYS_CLK_FREQ = 125000000,
    parameter int BAUD_RATE    = 115200,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    input  logic [1:0]                    parity_mode,
    output logic [DATA_BITS-1:0]          m_data,
    output logic                          m_parity_err,
    output logic                          m_frame_err,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          rts_n
);
    localparam longint TICK_RATE = longint'(BAUD_RATE) * longint'(OVERSAMPLE);
    localparam longint DIV_L     = (longint'(SYS_CLK_FREQ) + TICK_RATE / 2) / TICK_RATE;
    localparam int     DIV       = int'(DIV_L);
    localparam int     DIV_W     = (DIV < 2) ? 1 : $clog2(DIV);
    localparam int     OS_W      = $clog2(OVERSAMPLE);
    localparam int     BIT_W     = $clog2(DATA_BITS);
    localparam int     AW        = $clog2(FIFO_DEPTH);
    localparam int     W         = DATA_BITS + 2;

    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] MID_PT  = OS_W'(OVERSAMPLE / 2);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [OS_W-1:0] EARLY_PT  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] DECIDE_PT = OS_W'(OVERSAMPLE / 2 + 1);
`else
    localparam logic [OS_W-1:0] DECIDE_PT = MID_PT;
`endif

    if (DIV < 2) begin : g_div_check
        $error("uart_rx_os: tick divider must be at least 2");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic                 rx_meta_q, rx_sync_q;
    logic [DIV_W-1:0]     div_q;
    logic                 os_tick;
    state_t               state_q, state_d;
    logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_err_q, par_err_d;
    logic                 frm_err_q, frm_err_d;
    logic                 armed_q, armed_d;
    logic [1:0]           mode_q, mode_d;
    logic                 bit_val, decide, push;
    logic [W-1:0]         push_word;

    assign os_tick = (div_q == DIV_W'(DIV - 1));
    assign decide  = os_tick && (os_cnt_q == DECIDE_PT);

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] maj_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            maj_q <= '0;
        end else if (os_tick && state_q != IDLE) begin
            if (os_cnt_q == EARLY_PT) maj_q[0] <= rx_sync_q;
            if (os_cnt_q == MID_PT)   maj_q[1] <= rx_sync_q;
        end
    end
    assign bit_val = (maj_q[0] & maj_q[1]) | (maj_q[0] & rx_sync_q) | (maj_q[1] & rx_sync_q);
`else
    assign bit_val = rx_sync_q;
`endif

    always_comb begin
        state_d   = state_q;
        os_cnt_d  = os_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_err_d = par_err_q;
        frm_err_d = frm_err_q;
        armed_d   = armed_q;
        mode_d    = mode_q;
        push      = 1'b0;
        push_word = {frm_err_q | ~bit_val, par_err_q, shift_q};
        if (os_tick && state_q != IDLE)
            os_cnt_d = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + 1'b1;
        case (state_q)
            IDLE: begin
                if (os_tick) begin
                    if (armed_q && !rx_sync_q) begin
                        state_d   = START;
                        os_cnt_d  = '0;
                        bit_cnt_d = '0;
                        par_err_d = 1'b0;
                        frm_err_d = 1'b0;
                        mode_d    = parity_mode;
                    end else if (rx_sync_q) begin
                        armed_d = 1'b1;
                    end
                end
            end
            START: begin
                if (decide) begin
                    if (bit_val) begin
                        state_d = IDLE;
                        armed_d = 1'b0;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (decide) begin
                    shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = (mode_q == 2'b01 || mode_q == 2'b10) ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (decide) begin
                    par_err_d = ((^shift_q) ^ bit_val) != (mode_q == 2'b01);
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (decide) begin
                    if (!bit_val) frm_err_d = 1'b1;
                    // Clearing armed here stops a held-low (break) line from retriggering.
                    if (bit_cnt_q == BIT_W'(STOP_BITS - 1)) begin
                        push    = 1'b1;
                        armed_d = 1'b0;
                        state_d = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            div_q     <= '0;
            state_q   <= IDLE;
            os_cnt_q  <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            armed_q   <= 1'b0;
            mode_q    <= 2'b00;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            div_q     <= os_tick ? '0 : div_q + 1'b1;
            state_q   <= state_d;
            os_cnt_q  <= os_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
            armed_q   <= armed_d;
            mode_q    <= mode_d;
        end
    end

    logic [W-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          overrun_q, rts_n_q;
    logic          full, pop, push_ok;
    logic [W-1:0]  head;

    assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
    assign pop     = m_valid && m_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok = push && (!full || pop);

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop)
            count_d = count_q + 1'b1;
        else if (!push_ok && pop)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= push_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            rts_n_q   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q   <= count_d;
            overrun_q <= push && full && !pop;
            rts_n_q   <= (count_d >= (AW+1)'(FIFO_DEPTH - 2));
        end
    end

    assign head         = mem[rd_ptr_q];
    assign m_valid      = (count_q != '0);
    assign m_data       = m_valid ? head[DATA_BITS-1:0] : '0;
    assign m_parity_err = m_valid & head[DATA_BITS];
    assign m_frame_err  = m_valid & head[DATA_BITS+1];
    assign overrun      = overrun_q;
    assign fifo_count   = count_q;
    assign rts_n        = rts_n_q;
endmodule

// File: tb/tb_uart_rx_os.sv
// Directed testbench for uart_rx_os; baud chosen so the tick divider is 4 (64 clk per bit).
module tb_uart_rx_os;
    localparam int DIV_TB  = 4;
    localparam int BIT_CLK = 16 * DIV_TB;
    localparam int MID_OFF = 9 * DIV_TB - 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       m_ready = 1'b0;
    logic [1:0] parity_mode = 2'b00;
    logic [7:0] m_data;
    logic       m_parity_err, m_frame_err, m_valid, overrun, rts_n;
    logic [4:0] fifo_count;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int valid_cycles = 0;
    int overrun_cnt = 0;
    logic [9:0] got_q[$];

    always #5 clk = ~clk;

    uart_rx_os #(
        .DATA_BITS(8), .STOP_BITS(1), .OVERSAMPLE(16),
        .SYS_CLK_FREQ(125000000), .BAUD_RATE(1953125), .FIFO_DEPTH(16)
    ) dut (
        .clk(clk), .reset(reset), .rx(rx), .parity_mode(parity_mode),
        .m_data(m_data), .m_parity_err(m_parity_err), .m_frame_err(m_frame_err),
        .m_valid(m_valid), .m_ready(m_ready), .overrun(overrun),
        .fifo_count(fifo_count), .rts_n(rts_n)
    );

    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (m_valid) begin
                valid_cycles <= valid_cycles + 1;
                if (m_ready) got_q.push_back({m_frame_err, m_parity_err, m_data});
            end
            if (overrun) overrun_cnt <= overrun_cnt + 1;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Start every frame at a fixed divider phase so sample points are predictable.
    task automatic align();
        do @(negedge clk); while (cyc % DIV_TB != DIV_TB - 2);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par_en, input logic par_bit,
                              input logic stop_bit);
        align();
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (par_en) send_bit(par_bit);
        send_bit(stop_bit);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        checks++; if (m_valid !== 1'b0)      begin errors++; $display("FAIL reset_valid: got %b want 0", m_valid); end
        checks++; if (m_data !== 8'h00)      begin errors++; $display("FAIL reset_data: got %h want 00", m_data); end
        checks++; if (m_parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b want 0", m_parity_err); end
        checks++; if (m_frame_err !== 1'b0)  begin errors++; $display("FAIL reset_ferr: got %b want 0", m_frame_err); end
        checks++; if (overrun !== 1'b0)      begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        checks++; if (fifo_count !== 5'd0)   begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        checks++; if (rts_n !== 1'b0)        begin errors++; $display("FAIL reset_rts: got %b want 0", rts_n); end
        $display("reset: outputs checked");
    endtask

    task automatic test_basic();
        int base, v0;
        base = got_q.size();
        v0 = valid_cycles;
        m_ready = 1'b1;
        parity_mode = 2'b00;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        idle(BIT_CLK);
        checks++; if (got_q.size() - base != 1) begin errors++; $display("FAIL basic_words: got %0d want 1", got_q.size() - base); end
        checks++; if (got_q[base] !== 10'h0A5) begin errors++; $display("FAIL basic_word: got %h want 0a5", got_q[base]); end
        checks++; if (valid_cycles - v0 != 1) begin errors++; $display("FAIL basic_valid_cycles: got %0d want 1", valid_cycles - v0); end
        $display("basic: frame 0xA5 8N1 word=%h", got_q[base]);
    endtask

    task automatic test_parity();
        int base;
        base = got_q.size();
        m_ready = 1'b1;
        parity_mode = 2'b10;
        send_frame(8'h03, 1'b1, 1'b1, 1'b1);
        send_frame(8'h03, 1'b1, 1'b0, 1'b1);
        idle(BIT_CLK);
        parity_mode = 2'b00;
        checks++; if (got_q.size() - base != 2) begin errors++; $display("FAIL parity_words: got %0d want 2", got_q.size() - base); end
        checks++; if (got_q[base] !== 10'h103)   begin errors++; $display("FAIL parity_bad: got %h want 103", got_q[base]); end
        checks++; if (got_q[base+1] !== 10'h003) begin errors++; $display("FAIL parity_good: got %h want 003", got_q[base+1]); end
        $display("parity: even mode words=%h %h", got_q[base], got_q[base+1]);
    endtask

    task automatic test_frame_err();
        int base;
        base = got_q.size();
        m_ready = 1'b1;
        send_frame(8'h00, 1'b0, 1'b0, 1'b0);
        idle(30 * BIT_CLK);
        checks++; if (got_q.size() - base != 1) begin errors++; $display("FAIL break_words: got %0d want 1", got_q.size() - base); end
        checks++; if (got_q[base] !== 10'h200)  begin errors++; $display("FAIL break_word: got %h want 200", got_q[base]); end
        rx = 1'b1;
        idle(3 * BIT_CLK);
        checks++; if (got_q.size() - base != 1) begin errors++; $display("FAIL break_release: got %0d want 1", got_q.size() - base); end
        $display("frame_err: break produced word=%h", got_q[base]);
    endtask

    task automatic test_fifo_fill();
        int ov0, base;
        int exp_cnt;
        m_ready = 1'b0;
        ov0 = overrun_cnt;
        for (int k = 1; k <= 17; k++) begin
            send_frame(8'(32 + k), 1'b0, 1'b0, 1'b1);
            exp_cnt = (k > 16) ? 16 : k;
            checks++; if (fifo_count !== 5'(exp_cnt)) begin errors++; $display("FAIL fill_count%0d: got %0d want %0d", k, fifo_count, exp_cnt); end
            checks++; if (rts_n !== (k >= 14))        begin errors++; $display("FAIL fill_rts%0d: got %b want %b", k, rts_n, k >= 14); end
            checks++; if (overrun_cnt - ov0 != ((k == 17) ? 1 : 0)) begin errors++; $display("FAIL fill_overrun%0d: got %0d want %0d", k, overrun_cnt - ov0, (k == 17) ? 1 : 0); end
            $display("fill: frame %0d count=%0d rts_n=%b", k, fifo_count, rts_n);
        end
        base = got_q.size();
        m_ready = 1'b1;
        idle(24);
        checks++; if (got_q.size() - base != 16) begin errors++; $display("FAIL drain_words: got %0d want 16", got_q.size() - base); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (got_q[base+i] !== 10'(33 + i)) begin errors++; $display("FAIL drain_word%0d: got %h want %h", i, got_q[base+i], 10'(33 + i)); end
        end
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL drain_count: got %0d want 0", fifo_count); end
        checks++; if (rts_n !== 1'b0)      begin errors++; $display("FAIL drain_rts: got %b want 0", rts_n); end
        $display("drain: popped %0d words back to back", got_q.size() - base);
    endtask

    task automatic test_glitch();
        int base;
        base = got_q.size();
        m_ready = 1'b1;
        align();
        rx = 1'b0;
        idle(MID_OFF - 1);
        rx = 1'b1;
        idle(12 * BIT_CLK);
        checks++; if (got_q.size() != base) begin errors++; $display("FAIL glitch_words: got %0d want 0", got_q.size() - base); end
        checks++; if (fifo_count !== 5'd0)  begin errors++; $display("FAIL glitch_count: got %0d want 0", fifo_count); end
        $display("glitch: %0d-clk low pulse, words=%0d", MID_OFF - 1, got_q.size() - base);
    endtask

    task automatic test_reset_mid();
        int base;
        m_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
        checks++; if (fifo_count !== 5'd2) begin errors++; $display("FAIL rstmid_pre: got %0d want 2", fifo_count); end
        align();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        reset = 1'b1;
        rx = 1'b1;
        idle(3);
        reset = 1'b0;
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL rstmid_count: got %0d want 0", fifo_count); end
        checks++; if (m_valid !== 1'b0)    begin errors++; $display("FAIL rstmid_valid: got %b want 0", m_valid); end
        base = got_q.size();
        m_ready = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        idle(BIT_CLK);
        checks++; if (got_q.size() - base != 1) begin errors++; $display("FAIL rstmid_words: got %0d want 1", got_q.size() - base); end
        checks++; if (got_q[base] !== 10'h03C)  begin errors++; $display("FAIL rstmid_word: got %h want 03c", got_q[base]); end
        $display("reset_mid: recovered word=%h", got_q[base]);
    endtask

`ifdef UART_RX_MAJORITY_EN
    task automatic test_majority();
        int base;
        logic [7:0] d;
        d = 8'h5A;
        base = got_q.size();
        m_ready = 1'b1;
        align();
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                rx = d[i];
                idle(MID_OFF);
                rx = ~d[i];
                idle(1);
                rx = d[i];
                idle(BIT_CLK - MID_OFF - 1);
            end else begin
                send_bit(d[i]);
            end
        end
        send_bit(1'b1);
        idle(BIT_CLK);
        checks++; if (got_q.size() - base != 1) begin errors++; $display("FAIL maj_words: got %0d want 1", got_q.size() - base); end
        checks++; if (got_q[base] !== 10'h05A)  begin errors++; $display("FAIL maj_word: got %h want 05a", got_q[base]); end
        $display("majority: spiked frame word=%h", got_q[base]);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_frame_err();
        test_fifo_fill();
        test_glitch();
        test_reset_mid();
`ifdef UART_RX_MAJORITY_EN
        test_majority();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
